serial_word_tx_fsm: RTL

//  Transmit side of the serial-number stream used by the serial divisibility checkers. Accepts a

---
 rtl/serial_word_tx_fsm_pkg.sv | 11 +
 rtl/serial_word_tx_fsm_if.sv | 29 ++
 rtl/serial_word_tx_fsm_mod_step.sv | 26 ++
 rtl/serial_word_tx_fsm.sv | 106 ++++++++++
 4 files changed

// File: rtl/serial_word_tx_fsm_pkg.sv
// Shared types for the serial word transmitter and its receiver-side checkers.
package serial_tx_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;

  // Remainder register width for a given modulus (at least one bit).
  function automatic int unsigned rem_width(input int unsigned divisor);
    return (divisor < 2) ? 1 : $clog2(divisor);
  endfunction

endpackage

// File: rtl/serial_word_tx_fsm_if.sv
// Word-in / bit-out port bundle of the serial word transmitter.
interface serial_word_tx_fsm_if
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIVISOR = 5
);
  localparam int unsigned RW = rem_width(DIVISOR);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_bit;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic [RW-1:0]    out_rem;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_bit, out_valid, out_first, out_last, out_rem
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_bit, out_valid, out_first, out_last, out_rem
  );

endinterface

// File: rtl/serial_word_tx_fsm_mod_step.sv
// One step of the MSB-first remainder recurrence: rem_o = (2*rem_i + bit_i) mod DIVISOR.
module serial_mod_step
  import serial_tx_pkg::*;
#(
  parameter int unsigned DIVISOR = 5
) (
  input  logic [rem_width(DIVISOR)-1:0] rem_i,
  input  logic                          bit_i,
  output logic [rem_width(DIVISOR)-1:0] rem_o
);
  localparam int unsigned RW = rem_width(DIVISOR);
  localparam logic [RW:0] DIV_W = (RW+1)'(DIVISOR);

  logic [RW:0] t;

  // t never reaches 2*DIVISOR, so one conditional subtract is a full reduction
  always_comb begin
    t = {rem_i, bit_i};
    if (t >= DIV_W) begin
      rem_o = RW'(t - DIV_W);
    end else begin
      rem_o = t[RW-1:0];
    end
  end

endmodule

// File: rtl/serial_word_tx_fsm.sv
// Serial word transmitter: MSB-first shift-out with first/last framing and running prefix remainder.
module serial_word_tx_fsm
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIVISOR    = 5,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_word_tx_fsm_if.slave  tx,
  output logic                 busy
);
  localparam int unsigned RW = rem_width(DIVISOR);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    rem_step;
  logic             accept;

  serial_mod_step #(.DIVISOR(DIVISOR)) u_step (
    .rem_i (rem_q),
    .bit_i (shreg_q[WIDTH-1]),
    .rem_o (rem_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    rem_d        = rem_q;
    tx.in_ready  = 1'b0;
    tx.out_valid = 1'b0;
    tx.out_bit   = 1'b0;
    tx.out_first = 1'b0;
    tx.out_last  = 1'b0;
    tx.out_rem   = '0;

    unique case (state_q)
      TX_IDLE: tx.in_ready = !rst;
      TX_SHIFT: begin
        tx.out_valid = 1'b1;
        tx.out_bit   = shreg_q[WIDTH-1];
        tx.out_first = (cnt_q == CNT_TOP);
        tx.out_last  = (cnt_q == '0);
        tx.out_rem   = rem_step;
        shreg_d      = shreg_q << 1;
        cnt_d        = cnt_q - 1'b1;
        rem_d        = rem_step;
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = TX_GAP;
            gap_d   = GAP_TOP;
          end else begin
            // Without a gap the last-bit cycle doubles as the acceptance slot
            tx.in_ready = !rst;
            state_d     = TX_IDLE;
          end
        end
      end
      TX_GAP: begin
        if (gap_q == '0) begin
          state_d = TX_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    accept = tx.in_valid && tx.in_ready;
    if (accept) begin
      state_d = TX_SHIFT;
      shreg_d = tx.in_data;
      cnt_d   = CNT_TOP;
      rem_d   = '0;
    end
  end

  assign busy = (state_q != TX_IDLE);

endmodule
